// File: rtl/dff_onstate_burst.sv
// Per-channel IDLE/RUN/LAST burst tracker with registered run (r) and last (f) flags and a busy summary.
// Optional run-length capture (run_len/run_len_vld) is compiled in only when DFF_ONSTATE_RUNLEN_EN is defined.
module dff_onstate_burst #(
  parameter int CH       = 4,
  parameter int LAST_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  // activity level per channel ('do' itself is a reserved word)
  input  logic [CH-1:0]       do_lvl,
  output logic [CH-1:0]       r,
  output logic [CH-1:0]       f,
  output logic                busy,
  output logic [CH*CNT_W-1:0] run_len,
  output logic [CH-1:0]       run_len_vld
);

  localparam int LW = (LAST_CYC > 1) ? $clog2(LAST_CYC) : 1;
  localparam logic [LW-1:0] LAST_LOAD = LW'(LAST_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t        state     [CH];
  state_t        state_nxt [CH];
  logic [LW-1:0] last_cnt     [CH];
  logic [LW-1:0] last_cnt_nxt [CH];
  logic [CH-1:0] r_nxt;
  logic [CH-1:0] f_nxt;
  logic          busy_nxt;

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!rst_n) begin
        state[c]    <= IDLE;
        last_cnt[c] <= '0;
      end else begin
        state[c]    <= state_nxt[c];
        last_cnt[c] <= last_cnt_nxt[c];
      end
    end
  end

  // Retrigger from LAST is checked before the countdown expiry.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      state_nxt[c]    = state[c];
      last_cnt_nxt[c] = last_cnt[c];
      case (state[c])
        IDLE: begin
          if (do_lvl[c]) state_nxt[c] = RUN;
        end
        RUN: begin
          if (!do_lvl[c]) begin
            state_nxt[c]    = LAST;
            last_cnt_nxt[c] = LAST_LOAD;
          end
        end
        LAST: begin
          if (do_lvl[c]) begin
            state_nxt[c] = RUN;
          end else if (last_cnt[c] == '0) begin
            state_nxt[c] = IDLE;
          end else begin
            last_cnt_nxt[c] = last_cnt[c] - LW'(1);
          end
        end
        default: begin
          state_nxt[c]    = IDLE;
          last_cnt_nxt[c] = '0;
        end
      endcase
    end
  end

  always_comb begin
    r_nxt = '0;
    f_nxt = '0;
    for (int c = 0; c < CH; c++) begin
      r_nxt[c] = (state_nxt[c] == RUN);
      f_nxt[c] = (state_nxt[c] == LAST);
    end
    busy_nxt = |(r_nxt | f_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r    <= '0;
      f    <= '0;
      busy <= 1'b0;
    end else begin
      r    <= r_nxt;
      f    <= f_nxt;
      busy <= busy_nxt;
    end
  end

`ifdef DFF_ONSTATE_RUNLEN_EN
  logic [CNT_W-1:0] run_cnt [CH];
  logic [CH-1:0]    run_enter;
  logic [CH-1:0]    run_exit;

  always_comb begin
    run_enter = '0;
    run_exit  = '0;
    for (int c = 0; c < CH; c++) begin
      run_enter[c] = (state_nxt[c] == RUN) && (state[c] != RUN);
      run_exit[c]  = (state[c] == RUN) && (state_nxt[c] == LAST);
    end
  end

  // Counter saturates at all-ones; capture coincides with the f rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_len     <= '0;
      run_len_vld <= '0;
      for (int c = 0; c < CH; c++) run_cnt[c] <= '0;
    end else begin
      run_len_vld <= run_exit;
      for (int c = 0; c < CH; c++) begin
        if (run_enter[c]) begin
          run_cnt[c] <= CNT_W'(1);
        end else if (state_nxt[c] == RUN && run_cnt[c] != '1) begin
          run_cnt[c] <= run_cnt[c] + CNT_W'(1);
        end
        if (run_exit[c]) run_len[c*CNT_W +: CNT_W] <= run_cnt[c];
      end
    end
  end
`else
  assign run_len     = '0;
  assign run_len_vld = '0;
`endif

endmodule

// File: tb/tb_dff_onstate_burst.sv
// Bench for dff_onstate_burst: directed burst scenarios followed by random activity against a burst-level model.
module tb_dff_onstate_burst;

  localparam int CH       = 4;
  localparam int LAST_CYC = 2;
  localparam int CNT_W    = 3;
  localparam int SAT      = (1 << CNT_W) - 1;
`ifdef DFF_ONSTATE_RUNLEN_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [CH-1:0]       do_lvl;
  logic [CH-1:0]       r;
  logic [CH-1:0]       f;
  logic                busy;
  logic [CH*CNT_W-1:0] run_len;
  logic [CH-1:0]       run_len_vld;

  dff_onstate_burst #(.CH(CH), .LAST_CYC(LAST_CYC), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .do_lvl      (do_lvl),
    .r           (r),
    .f           (f),
    .busy        (busy),
    .run_len     (run_len),
    .run_len_vld (run_len_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Burst model: active run flag, remaining tail cycles, run length so far, last captured length.
  bit m_run  [CH];
  int m_tail [CH];
  int m_cnt  [CH];
  int m_len  [CH];
  bit m_vld  [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] d, input logic rs);
    for (int c = 0; c < CH; c++) begin
      m_vld[c] = 1'b0;
      if (!rs) begin
        m_run[c] = 1'b0; m_tail[c] = 0; m_cnt[c] = 0; m_len[c] = 0;
      end else if (m_run[c]) begin
        if (d[c]) begin
          m_cnt[c] = (m_cnt[c] < SAT) ? m_cnt[c] + 1 : SAT;
        end else begin
          m_run[c]  = 1'b0;
          m_tail[c] = LAST_CYC;
          m_len[c]  = m_cnt[c];
          m_vld[c]  = 1'b1;
        end
      end else if (m_tail[c] > 0) begin
        if (d[c]) begin
          m_run[c] = 1'b1; m_tail[c] = 0; m_cnt[c] = 1;
        end else begin
          m_tail[c] = m_tail[c] - 1;
        end
      end else if (d[c]) begin
        m_run[c] = 1'b1; m_cnt[c] = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [CH-1:0]       er, ef, ev;
    logic [CH*CNT_W-1:0] el;
    logic                eb;
    er = '0; ef = '0; ev = '0; el = '0;
    for (int c = 0; c < CH; c++) begin
      er[c] = m_run[c];
      ef[c] = (m_tail[c] > 0);
      if (EN) begin
        ev[c] = m_vld[c];
        el[c*CNT_W +: CNT_W] = CNT_W'(m_len[c]);
      end
    end
    eb = |(er | ef);
    chk("r", 32'(r), 32'(er));
    chk("f", 32'(f), 32'(ef));
    chk("busy", 32'(busy), 32'(eb));
    chk("run_len", 32'(run_len), 32'(el));
    chk("run_len_vld", 32'(run_len_vld), 32'(ev));
  endtask

  task automatic step(input logic [CH-1:0] d, input logic rs);
    do_lvl = d;
    rst_n  = rs;
    @(posedge clk);
    model_edge(d, rs);
    #1;
    check_all();
  endtask

  int busy_cycles;
  logic [CH-1:0] rd;

  initial begin
    rst_n  = 1'b0;
    do_lvl = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 1'b0; m_tail[c] = 0; m_cnt[c] = 0; m_len[c] = 0; m_vld[c] = 1'b0;
    end

    step('0, 1'b0);
    step(4'b1111, 1'b0);

    // Single burst on ch0: 3 run cycles then a 2-cycle tail
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      step((i < 3) ? 4'b0001 : 4'b0000, 1'b1);
      if (busy) busy_cycles++;
    end
    chk("busy_cycles_ch0", 32'(busy_cycles), 32'd5);
    chk("len_ch0", 32'(run_len[0 +: CNT_W]), EN ? 32'd3 : 32'd0);

    // Retrigger from the tail on ch1
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b1);
    chk("retrig_r1", 32'(r[1]), 32'd1);
    chk("retrig_busy", 32'(busy), 32'd1);
    step(4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("retrig_len", 32'(run_len[CNT_W +: CNT_W]), EN ? 32'd2 : 32'd0);

    // Saturating run length on ch2
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("sat_len", 32'(run_len[2*CNT_W +: CNT_W]), EN ? 32'(SAT) : 32'd0);

    // Concurrent bursts on ch0 (length 1) and ch3 (length 4)
    step(4'b1001, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);

    // Reset while ch0 is running, activity held high
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    chk("rst_mid_r", 32'(r), 32'd0);
    step(4'b0001, 1'b1);
    chk("rst_resume_r", 32'(r[0]), 32'd1);
    step(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

    // Toggling activity every cycle
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

    // Random activity with occasional resets
    for (int i = 0; i < 400; i++) begin
      rd = CH'($urandom);
      if ($urandom_range(0, 2) == 0) rd = rd & CH'($urandom);
      step(rd, ($urandom_range(0, 49) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_onstate_burst.md
DFF_ONSTATE_BURST -- requirements
Module: dff_onstate_burst

Interface
REQ-001 Parameter CH, default 4: number of independent channels, at least 1.
REQ-002 Parameter LAST_CYC, default 2: cycles spent in LAST per burst end, at least 1.
REQ-003 Parameter CNT_W, default 8: run-length counter width, at least 2.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 do  input  CH  per-channel activity level, sampled on each clk edge.
REQ-007 r  output  CH  per-channel RUN indication, registered.
REQ-008 f  output  CH  per-channel LAST indication, registered.
REQ-009 busy  output  1  registered; 1 when any channel's next state is not IDLE.
REQ-010 run_len  output  CH*CNT_W  channel c occupies bits [c*CNT_W +: CNT_W]; last captured run length.
REQ-011 run_len_vld  output  CH  one-cycle pulse per channel when run_len[c] updates.

Function
REQ-012 Each channel shall run an independent FSM with states IDLE, RUN and LAST, and a LAST down-counter.
REQ-013 IDLE shall go to RUN when do[c]=1, and otherwise hold.
REQ-014 RUN shall go to LAST when do[c]=0, and otherwise hold; the LAST counter loads LAST_CYC-1 on that transition.
REQ-015 LAST shall go to RUN when do[c]=1 (retrigger, checked first).
REQ-016 Otherwise LAST shall go to IDLE when the LAST counter is 0, and otherwise decrement the counter and hold.
REQ-017 Outputs shall be registered from the next state: r[c]<=(next==RUN) and f[c]<=(next==LAST), so they align with the state register and change one cycle after the do sample.
REQ-018 busy shall be registered as the OR over channels of (next!=IDLE).
REQ-019 Run counter: loads 1 on any entry to RUN (from IDLE or LAST), increments by 1 per further cycle in RUN, and saturates at 2^CNT_W-1 without wrapping.
REQ-020 On a RUN->LAST transition, run_len[c] shall take the counter value and run_len_vld[c] shall be 1 for exactly one cycle, coincident with the rising edge of f[c].
REQ-021 run_len[c] shall hold its value until the next capture.
REQ-022 Simultaneous events on different channels shall be fully independent, with no priority or arbitration.
REQ-023 Transitions where do toggles every cycle shall follow REQ-013..016 exactly, with no filtering.

Reset
REQ-024 While rst_n=0 at a clk edge, all states shall be IDLE, all counters 0, and r, f, busy, run_len and run_len_vld shall be 0.
REQ-025 Reset asserted mid-burst shall abort the burst with no run_len_vld pulse.
REQ-026 After reset, the first edge with rst_n=1 shall evaluate do normally.

Configuration
REQ-027 Macro DFF_ONSTATE_RUNLEN_EN, when defined, shall compile in the run counters and the run_len/run_len_vld logic per REQ-019..021.
REQ-028 When DFF_ONSTATE_RUNLEN_EN is undefined, run_len and run_len_vld shall be tied to 0, no counter flops shall exist, and the FSM, r, f and busy behaviour shall be unchanged.

Verification
REQ-029 Ch0, LAST_CYC=2, do[0] high for 3 samples then low -> r[0] high 3 cycles, then f[0] high 2 cycles; run_len[0]=3 with vld pulse at the f rise; busy high 5 cycles.
REQ-030 Ch1, do[1]=0 for 1 sample during LAST, then 1 (retrigger) -> f[1] high 1 cycle, r[1] re-asserts directly, no IDLE gap, busy stays 1, counter restarts at 1.
REQ-031 CNT_W=2, do[2] high 6 samples -> run_len[2]=3 (saturated), not 2.
REQ-032 Channels 0 and 3 start bursts on the same edge with lengths 1 and 4 -> independent r/f; run_len=1 and 4 with vld on separate cycles.
REQ-033 rst_n=0 for 1 cycle while ch0 is in RUN -> all outputs 0 on the next cycle, no vld pulse; with do[0]=1 held, r[0] re-asserts 1 cycle after rst_n returns to 1.
REQ-034 Build without DFF_ONSTATE_RUNLEN_EN and rerun REQ-029 -> r, f and busy are identical; run_len and run_len_vld stay 0.
